// File: rtl/dlx_pkg.sv
// dlx_pkg: shared DLX ISA definitions used by the instruction encoder and decoder.
//   - Opcode and ALU function-code constants, including the OP_ALUI pseudo-op.
//   - Instruction field bit positions.
//   - alui_opcode(): maps an ALU func code to its immediate-form opcode.
//   - op_format(): classifies an opcode as R, I or J format.
package dlx_pkg;

  // Opcodes
  localparam logic [5:0] OP_RALU  = 6'h00;
  localparam logic [5:0] OP_FP    = 6'h01;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQZ  = 6'h04;
  localparam logic [5:0] OP_BNEZ  = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDUI = 6'h09;
  localparam logic [5:0] OP_SUBI  = 6'h0A;
  localparam logic [5:0] OP_SUBUI = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_JR    = 6'h12;
  localparam logic [5:0] OP_JALR  = 6'h13;
  localparam logic [5:0] OP_SLLI  = 6'h14;
  localparam logic [5:0] OP_SRLI  = 6'h16;
  localparam logic [5:0] OP_SRAI  = 6'h17;
  localparam logic [5:0] OP_SEQI  = 6'h18;
  localparam logic [5:0] OP_SNEI  = 6'h19;
  localparam logic [5:0] OP_SLTI  = 6'h1A;
  localparam logic [5:0] OP_SGTI  = 6'h1B;
  localparam logic [5:0] OP_SLEI  = 6'h1C;
  localparam logic [5:0] OP_SGEI  = 6'h1D;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;
  // Pseudo-op: immediate ALU op whose real opcode comes from the func field
  localparam logic [5:0] OP_ALUI  = 6'h3F;

  // R-type ALU function codes
  localparam logic [5:0] FN_SLL  = 6'h04;
  localparam logic [5:0] FN_SRL  = 6'h06;
  localparam logic [5:0] FN_SRA  = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_SEQ  = 6'h28;
  localparam logic [5:0] FN_SNE  = 6'h29;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SGT  = 6'h2B;
  localparam logic [5:0] FN_SLE  = 6'h2C;
  localparam logic [5:0] FN_SGE  = 6'h2D;

  // Field LSB positions
  localparam int unsigned OP_LSB    = 26;
  localparam int unsigned RS1_LSB   = 21;
  localparam int unsigned RS2_LSB   = 16;
  localparam int unsigned RD_R_LSB  = 11;
  localparam int unsigned RD_I_LSB  = 16;
  localparam int unsigned FUNC_LSB  = 0;
  localparam int unsigned IMM_LSB   = 0;
  localparam int unsigned JIMM_LSB  = 0;

  typedef enum logic [1:0] {FmtR, FmtI, FmtJ} fmt_e;

  typedef struct packed {
    logic       valid;
    logic [5:0] op;
  } alui_map_t;

  function automatic alui_map_t alui_opcode(input logic [5:0] func);
    alui_map_t m;
    m.valid = 1'b1;
    case (func)
      FN_ADD:  m.op = OP_ADDI;
      FN_ADDU: m.op = OP_ADDUI;
      FN_SUB:  m.op = OP_SUBI;
      FN_SUBU: m.op = OP_SUBUI;
      FN_AND:  m.op = OP_ANDI;
      FN_OR:   m.op = OP_ORI;
      FN_XOR:  m.op = OP_XORI;
      FN_SLL:  m.op = OP_SLLI;
      FN_SRL:  m.op = OP_SRLI;
      FN_SRA:  m.op = OP_SRAI;
      FN_SEQ:  m.op = OP_SEQI;
      FN_SNE:  m.op = OP_SNEI;
      FN_SLT:  m.op = OP_SLTI;
      FN_SGT:  m.op = OP_SGTI;
      FN_SLE:  m.op = OP_SLEI;
      FN_SGE:  m.op = OP_SGEI;
      default: begin
        m.valid = 1'b0;
        m.op    = 6'h00;
      end
    endcase
    return m;
  endfunction

  function automatic fmt_e op_format(input logic [5:0] op);
    fmt_e f;
    case (op)
      OP_RALU, OP_FP: f = FmtR;
      OP_J, OP_JAL:   f = FmtJ;
      default:        f = FmtI;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/dlx_enc_fifo.sv
// dlx_enc_fifo: Depth x Width synchronous FIFO with occupancy count.
//   clk_i   - clock, rising edge
//   rst_ni  - synchronous active-low reset (clears pointers and count)
//   push_i  - write data_i (ignored when full)
//   pop_i   - drop head entry (ignored when empty)
//   data_i  - write data
//   data_o  - head entry (undefined contents while empty)
//   count_o - occupancy 0..Depth
//   empty_o / full_o - status
module dlx_enc_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [Width-1:0]         data_i,
  output logic [Width-1:0]         data_o,
  output logic [$clog2(Depth):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_en, pop_en;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(Depth));
  assign push_en = push_i & ~full_o;
  assign pop_en  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Depth is a power of two, so pointers wrap by natural overflow
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_en, pop_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; empty masking is done by the consumer
  always_ff @(posedge clk_i) begin
    if (push_en) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/dlx_inst_encoder.sv
// dlx_inst_encoder: packs DLX instruction fields into 32-bit words, queues them in a
// FIFO and writes them to instruction memory at an auto-incrementing byte address.
//   clk, rst_n        - clock (rising edge), synchronous active-low reset
//   in_valid/in_ready - field bundle handshake
//   in_op .. in_jimm  - instruction fields; in_op = OP_ALUI selects immediate ALU form
//   addr_load/addr_val- overwrite the write address counter
//   mem_wr/mem_ready  - imem write handshake; mem_addr/mem_data carry address and word
//   empty, count      - FIFO status
//   err               - sticky: an OP_ALUI bundle with an unmapped func was seen
//   err_count         - saturating illegal-bundle count
// Build option: define DLX_ENC_ERRCNT_EN to implement err_count; otherwise it reads 0.
module dlx_inst_encoder
  import dlx_pkg::*;
#(
  parameter int unsigned         DEPTH      = 4,
  parameter int unsigned         ADDR_W     = 32,
  parameter logic [ADDR_W-1:0]   RESET_ADDR = '0,
  parameter int unsigned         ADDR_STEP  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [5:0]             in_op,
  input  logic [5:0]             in_func,
  input  logic [4:0]             in_rs1,
  input  logic [4:0]             in_rs2,
  input  logic [4:0]             in_rd,
  input  logic [15:0]            in_imm,
  input  logic [25:0]            in_jimm,
  input  logic                   addr_load,
  input  logic [ADDR_W-1:0]      addr_val,
  output logic                   mem_wr,
  input  logic                   mem_ready,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [31:0]            mem_data,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   err,
  output logic [7:0]             err_count
);

  logic [31:0]       enc_word;
  logic              enc_illegal;
  alui_map_t         alui;
  logic              accept, push, pop;
  logic              fifo_full, fifo_empty;
  logic [31:0]       fifo_head;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;

  // Field packing
  always_comb begin
    enc_word    = '0;
    enc_illegal = 1'b0;
    alui        = alui_opcode(in_func);
    unique case (op_format(in_op))
      FmtR: enc_word = {in_op, in_rs1, in_rs2, in_rd, 5'b0, in_func};
      FmtJ: enc_word = {in_op, in_jimm};
      FmtI: begin
        if (in_op == OP_ALUI) begin
          if (alui.valid) enc_word = {alui.op, in_rs1, in_rd, in_imm};
          else            enc_illegal = 1'b1;
        end else begin
          enc_word = {in_op, in_rs1, in_rd, in_imm};
        end
      end
      default: enc_word = '0;
    endcase
  end

  assign in_ready = rst_n & ~fifo_full;
  assign accept   = in_valid & in_ready;
  // Illegal bundles complete the handshake but never reach the queue
  assign push     = accept & ~enc_illegal;
  assign pop      = mem_wr & mem_ready;

  dlx_enc_fifo #(
    .Depth (DEPTH),
    .Width (32)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (enc_word),
    .data_o  (fifo_head),
    .count_o (count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign empty    = fifo_empty;
  assign mem_wr   = ~fifo_empty;
  // Stale storage is hidden so the bus reads 0 whenever nothing is queued
  assign mem_data = fifo_empty ? 32'h0 : fifo_head;
  assign mem_addr = addr_q;

  // Address counter: explicit load wins over the post-write increment
  always_comb begin
    addr_d = addr_q;
    if (addr_load)  addr_d = addr_val;
    else if (pop)   addr_d = addr_q + ADDR_W'(ADDR_STEP);
  end

  assign err_d = err_q | (accept & enc_illegal);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q <= RESET_ADDR;
      err_q  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      err_q  <= err_d;
    end
  end

  assign err = err_q;

`ifdef DLX_ENC_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (accept && enc_illegal && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) err_cnt_q <= 8'd0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_dlx_inst_encoder.sv
// Directed bench for dlx_inst_encoder (default parameters: DEPTH=4, ADDR_W=32,
// RESET_ADDR=0, ADDR_STEP=4). Inputs change 1 time unit after a rising edge and
// outputs are sampled there as well.
module tb_dlx_inst_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_op;
  logic [5:0]  in_func;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [4:0]  in_rd;
  logic [15:0] in_imm;
  logic [25:0] in_jimm;
  logic        addr_load;
  logic [31:0] addr_val;
  logic        mem_wr;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        empty;
  logic [2:0]  count;
  logic        err;
  logic [7:0]  err_count;

  int n_checks = 0;
  int n_errors = 0;

`ifdef DLX_ENC_ERRCNT_EN
  localparam logic [7:0] ErrCntAfterOne = 8'd1;
`else
  localparam logic [7:0] ErrCntAfterOne = 8'd0;
`endif

  dlx_inst_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_func   (in_func),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_rd     (in_rd),
    .in_imm    (in_imm),
    .in_jimm   (in_jimm),
    .addr_load (addr_load),
    .addr_val  (addr_val),
    .mem_wr    (mem_wr),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .empty     (empty),
    .count     (count),
    .err       (err),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one bundle for exactly one edge
  task automatic push1(input logic [5:0] op, input logic [5:0] func, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd, input logic [15:0] imm,
                       input logic [25:0] jimm);
    in_op = op; in_func = func; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
    in_imm = imm; in_jimm = jimm; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  logic [31:0] bp_exp [5];

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_func = '0; in_rs1 = '0; in_rs2 = '0;
    in_rd = '0; in_imm = '0; in_jimm = '0; addr_load = 1'b0; addr_val = '0;
    mem_ready = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_empty", {31'b0, empty}, 32'd1);
    chk("rst_count", {29'b0, count}, 32'd0);
    chk("rst_mem_wr", {31'b0, mem_wr}, 32'd0);
    chk("rst_mem_data", mem_data, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_err_count", {24'b0, err_count}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

    // Single words, drained one edge after acceptance
    mem_ready = 1'b1;
    push1(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    chk("add_mem_wr", {31'b0, mem_wr}, 32'd1);
    chk("add_data", mem_data, 32'h00221820);
    chk("add_addr", mem_addr, 32'h0);
    tick();
    chk("add_drained", {31'b0, empty}, 32'd1);
    chk("add_next_addr", mem_addr, 32'h4);

    push1(6'h3F, 6'h20, 5'd1, 5'd0, 5'd3, 16'h0005, 26'h0);
    chk("addi_data", mem_data, 32'h20230005);
    chk("addi_addr", mem_addr, 32'h4);
    tick();
    push1(6'h3F, 6'h04, 5'd1, 5'd0, 5'd3, 16'h0005, 26'h0);
    chk("slli_data", mem_data, 32'h50230005);
    tick();
    push1(6'h02, 6'h00, 5'd0, 5'd0, 5'd0, 16'h0, 26'h100);
    chk("j_data", mem_data, 32'h08000100);
    chk("j_addr", mem_addr, 32'hC);
    tick();
    push1(6'h03, 6'h00, 5'd0, 5'd0, 5'd0, 16'h0, 26'h100);
    chk("jal_data", mem_data, 32'h0C000100);
    tick();
    push1(6'h23, 6'h00, 5'd2, 5'd0, 5'd5, 16'hFFF0, 26'h0);
    chk("lw_data", mem_data, 32'h8C45FFF0);
    chk("lw_addr", mem_addr, 32'h14);
    tick();
    chk("after_lw_addr", mem_addr, 32'h18);

    // Backpressure: 4 fill the FIFO, the 5th waits
    mem_ready = 1'b0;
    bp_exp[0] = 32'h00220820; bp_exp[1] = 32'h00221020; bp_exp[2] = 32'h00221820;
    bp_exp[3] = 32'h00222020; bp_exp[4] = 32'h00222820;
    in_op = 6'h00; in_func = 6'h20; in_rs1 = 5'd1; in_rs2 = 5'd2;
    for (int i = 1; i <= 4; i++) begin
      in_rd = 5'(i);
      in_valid = 1'b1;
      tick();
    end
    chk("bp_count_full", {29'b0, count}, 32'd4);
    chk("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
    in_rd = 5'd5;
    tick();
    chk("bp_count_hold", {29'b0, count}, 32'd4);
    chk("bp_mem_wr_high", {31'b0, mem_wr}, 32'd1);
    chk("bp_head_stable", mem_data, bp_exp[0]);
    mem_ready = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_data%0d", k), mem_data, bp_exp[k]);
      chk($sformatf("bp_addr%0d", k), mem_addr, 32'h18 + 32'(4 * k));
      tick();
      if (k == 0) chk("bp_count_after_pop", {29'b0, count}, 32'd3);
      if (k == 1) begin
        chk("bp_count_push_pop", {29'b0, count}, 32'd3);
        in_valid = 1'b0;
      end
    end
    chk("bp_empty", {31'b0, empty}, 32'd1);
    chk("bp_final_addr", mem_addr, 32'h2C);

    // Illegal ALUI func
    push1(6'h3F, 6'h3E, 5'd1, 5'd0, 5'd3, 16'h0005, 26'h0);
    chk("ill_mem_wr", {31'b0, mem_wr}, 32'd0);
    chk("ill_err", {31'b0, err}, 32'd1);
    chk("ill_err_count", {24'b0, err_count}, {24'b0, ErrCntAfterOne});
    push1(6'h3F, 6'h20, 5'd1, 5'd0, 5'd3, 16'h0005, 26'h0);
    chk("ill_next_data", mem_data, 32'h20230005);
    chk("ill_next_addr", mem_addr, 32'h2C);
    tick();
    chk("ill_err_sticky", {31'b0, err}, 32'd1);
    chk("ill_addr_after", mem_addr, 32'h30);

    // addr_load during a transfer, then wrap
    mem_ready = 1'b0;
    push1(6'h00, 6'h20, 5'd1, 5'd2, 5'd1, 16'h0, 26'h0);
    push1(6'h00, 6'h20, 5'd1, 5'd2, 5'd2, 16'h0, 26'h0);
    push1(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    mem_ready = 1'b1; addr_load = 1'b1; addr_val = 32'hFFFFFFFC;
    #1;
    chk("ld_w1_addr", mem_addr, 32'h30);
    chk("ld_w1_data", mem_data, bp_exp[0]);
    tick();
    addr_load = 1'b0;
    chk("ld_w2_addr", mem_addr, 32'hFFFFFFFC);
    chk("ld_w2_data", mem_data, bp_exp[1]);
    tick();
    chk("ld_w3_addr", mem_addr, 32'h0);
    chk("ld_w3_data", mem_data, bp_exp[2]);
    tick();
    chk("ld_empty", {31'b0, empty}, 32'd1);
    chk("ld_final_addr", mem_addr, 32'h4);

    // Reset with queued words
    mem_ready = 1'b0;
    push1(6'h00, 6'h20, 5'd1, 5'd2, 5'd1, 16'h0, 26'h0);
    push1(6'h00, 6'h20, 5'd1, 5'd2, 5'd2, 16'h0, 26'h0);
    push1(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    chk("rq_count", {29'b0, count}, 32'd3);
    rst_n = 1'b0;
    #1;
    chk("rq_in_ready", {31'b0, in_ready}, 32'd0);
    tick();
    chk("rq_empty", {31'b0, empty}, 32'd1);
    chk("rq_count0", {29'b0, count}, 32'd0);
    chk("rq_mem_wr", {31'b0, mem_wr}, 32'd0);
    chk("rq_mem_addr", mem_addr, 32'h0);
    chk("rq_mem_data", mem_data, 32'h0);
    chk("rq_err", {31'b0, err}, 32'd0);
    rst_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
